// File: rtl/mux_nx1_scan.sv
// Registered N-channel selector: manual select or round-robin scan with a
// programmable dwell per channel, one cycle from sampled inputs to y.
module mux_nx1_scan #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]        y,
  output logic [SEL_W-1:0]         ch_out,
  output logic                     y_valid,
  output logic                     sel_err,
  output logic                     wrap
);

  generate
    if ((2 ** SEL_W) < N_CH) begin : g_sel_w_check
      $error("mux_nx1_scan: SEL_W too narrow for N_CH");
    end
    if (DWELL < 1 || DWELL > 255) begin : g_dwell_check
      $error("mux_nx1_scan: DWELL must be 1..255");
    end
    if (N_CH < 2 || N_CH > 16) begin : g_nch_check
      $error("mux_nx1_scan: N_CH must be 2..16");
    end
  endgenerate

  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_W     = (SEL_W + 1)'(N_CH);
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic {
    IDLE_MAN = 1'b0,
    SCAN     = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] pick_ch(
    input logic [N_CH*DATA_W-1:0] d,
    input logic [SEL_W-1:0]       idx
  );
    logic [DATA_W-1:0] res;
    res = {DATA_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      res = (idx == SEL_W'(k)) ? d[k*DATA_W +: DATA_W] : res;
    end
    return res;
  endfunction

  state_t             state_r, state_s;
  logic [SEL_W-1:0]   scan_ch_r, scan_ch_s;
  logic [7:0]         dwell_r, dwell_s;
  logic [DATA_W-1:0]  y_r, y_s;
  logic [SEL_W-1:0]   ch_r, ch_s;
  logic               valid_r, valid_s;
  logic               err_r, err_s;
  logic               wrap_r, wrap_s;
  logic [SEL_W-1:0]   cur_ch_s;
  logic [7:0]         cur_dwell_s;

  // State and output registers; the whole block freezes when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE_MAN;
      scan_ch_r <= {SEL_W{1'b0}};
      dwell_r   <= 8'd0;
      y_r       <= {DATA_W{1'b0}};
      ch_r      <= {SEL_W{1'b0}};
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      scan_ch_r <= scan_ch_s;
      dwell_r   <= dwell_s;
      y_r       <= y_s;
      ch_r      <= ch_s;
      valid_r   <= valid_s;
      err_r     <= err_s;
      wrap_r    <= wrap_s;
    end
  end

  // Next-state and output selection for manual and scan modes.
  always_comb begin
    state_s     = state_r;
    scan_ch_s   = scan_ch_r;
    dwell_s     = dwell_r;
    y_s         = y_r;
    ch_s        = ch_r;
    valid_s     = 1'b0;
    err_s       = err_r;
    wrap_s      = 1'b0;
    // Entering scan always starts from channel 0 with a fresh dwell count.
    cur_ch_s    = (state_r == SCAN) ? scan_ch_r : {SEL_W{1'b0}};
    cur_dwell_s = (state_r == SCAN) ? dwell_r : 8'd0;
    if (en) begin
      case (mode)
        1'b0: begin
          state_s   = IDLE_MAN;
          scan_ch_s = {SEL_W{1'b0}};
          dwell_s   = 8'd0;
          ch_s      = sel_in;
          valid_s   = 1'b1;
          if ({1'b0, sel_in} < N_CH_W) begin
            y_s   = pick_ch(data_in, sel_in);
            err_s = 1'b0;
          end else begin
            y_s   = {DATA_W{1'b0}};
            err_s = 1'b1;
          end
        end
        1'b1: begin
          state_s = SCAN;
          y_s     = pick_ch(data_in, cur_ch_s);
          ch_s    = cur_ch_s;
          valid_s = 1'b1;
          err_s   = 1'b0;
          // Channel 0 at dwell 0 while already scanning is only reachable
          // right after a wrap, so the pulse lines up with ch_out returning to 0.
          wrap_s  = (state_r == SCAN) && (cur_ch_s == {SEL_W{1'b0}}) &&
                    (cur_dwell_s == 8'd0);
          if (cur_dwell_s == DWELL_LAST) begin
            dwell_s   = 8'd0;
            scan_ch_s = (cur_ch_s == LAST_CH) ? {SEL_W{1'b0}} : cur_ch_s + {{(SEL_W-1){1'b0}}, 1'b1};
          end else begin
            dwell_s   = cur_dwell_s + 8'd1;
            scan_ch_s = cur_ch_s;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign y       = y_r;
  assign ch_out  = ch_r;
  assign y_valid = valid_r;
  assign sel_err = err_r;
  assign wrap    = wrap_r;

endmodule
